weight_access_arbiter: RTL and testbench



---
 rtl/weight_mem_pkg.sv | 9 +
 rtl/weight_access_arbiter_rr_arbiter.sv | 32 +++
 rtl/weight_access_arbiter.sv | 111 +++++++++++
 tb/tb_weight_access_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_mem_pkg.sv
// weight_mem_pkg: shared types and defaults for the synaptic weight memory path
package weight_mem_pkg;
  typedef enum logic [1:0] {RUN, DRAIN, LOCKED} arb_state_t;
  localparam logic RSP_OK        = 1'b0;
  localparam logic RSP_ERR_RANGE = 1'b1;
  localparam int DEF_NUM_SYNAPSES = 72832;
  localparam int DEF_ADDR_W       = 17;
  localparam int DEF_DATA_W       = 16;
endpackage

// File: rtl/weight_access_arbiter_rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over NUM_REQ requesters with a self-advancing pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic               adv,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);
  logic [IDX_W-1:0] rr_ptr;
  logic             hit;
  // scan from the farthest slot back toward rr_ptr so the nearest requester wins
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (en && req[(int'(rr_ptr) + k) % NUM_REQ]) begin
        hit = 1'b1;
        idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
    gnt = hit ? NUM_REQ'(1) << idx : '0;
  end
  // pointer moves to the slot after the requester just served
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rr_ptr <= '0;
    else if (adv) rr_ptr <= idx == IDX_W'(NUM_REQ - 1) ? '0 : idx + 1'b1;
endmodule

// File: rtl/weight_access_arbiter.sv
// weight_access_arbiter: shares a single-port weight RAM between round-robin readers and a host write port
module weight_access_arbiter import weight_mem_pkg::*; #(
  parameter int NUM_REQ      = 4,
  parameter int NUM_SYNAPSES = DEF_NUM_SYNAPSES,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int WR_BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        rd_valid,
  output logic [NUM_REQ-1:0]        rd_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] rd_addr,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  input  logic                      cfg_wr_valid,
  output logic                      cfg_wr_ready,
  input  logic [ADDR_W-1:0]         cfg_wr_addr,
  input  logic [DATA_W-1:0]         cfg_wr_data,
  output logic                      cfg_wr_err,
  input  logic                      cfg_lock,
  output logic                      lock_ack,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);
  localparam int IDX_W = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int STK_W = $clog2(WR_BURST_MAX + 1);
  arb_state_t       state, next_state;
  logic [STK_W-1:0] wr_streak;
  logic [IDX_W-1:0] rd_idx, s1_tag, s2_tag;
  logic             s1_v, s2_v, s1_err, s2_err;
  logic             rd_pending, rd_open, force_rd, wr_gnt, rd_gnt, rd_in, wr_in;
  logic [ADDR_W-1:0] sel_addr;
  assign rd_pending   = |rd_valid;
  assign rd_open      = rst_n && state == RUN && !cfg_lock;
  assign force_rd     = rd_pending && rd_open && wr_streak == STK_W'(WR_BURST_MAX);
  assign wr_gnt       = rst_n && cfg_wr_valid && !force_rd;
  assign cfg_wr_ready = wr_gnt;
  assign rd_gnt       = |rd_ready;
  assign sel_addr     = rd_addr[rd_idx*ADDR_W +: ADDR_W];
  assign rd_in        = 32'(sel_addr) < NUM_SYNAPSES;
  assign wr_in        = 32'(cfg_wr_addr) < NUM_SYNAPSES;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .clk  (clk),
    .rst_n(rst_n),
    .req  (rd_valid),
    .en   (rd_open && !wr_gnt),
    .adv  (rd_gnt),
    .gnt  (rd_ready),
    .idx  (rd_idx)
  );
  // lock sequencing: a lock request stops reads, then waits for the read pipeline to empty
  always_comb
    next_state = state == RUN ? (cfg_lock ? DRAIN : RUN)
               : !cfg_lock ? RUN
               : (state == DRAIN && !s1_v && !s2_v) ? LOCKED : state;
  // state, lock acknowledge and write-burst streak
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= RUN;
      lock_ack  <= 1'b0;
      wr_streak <= '0;
    end else begin
      state     <= next_state;
      lock_ack  <= next_state == LOCKED;
      wr_streak <= (!rd_pending || rd_gnt) ? '0
                 : (wr_gnt && wr_streak != STK_W'(WR_BURST_MAX)) ? wr_streak + 1'b1 : wr_streak;
    end
  // RAM strobes issued one cycle after the grant; out-of-range accesses never reach the RAM
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cfg_wr_err <= 1'b0;
    end else begin
      mem_en     <= (rd_gnt && rd_in) || (wr_gnt && wr_in);
      mem_we     <= wr_gnt && wr_in;
      cfg_wr_err <= wr_gnt && !wr_in;
      if (wr_gnt || rd_gnt) mem_addr <= wr_gnt ? cfg_wr_addr : sel_addr;
      if (wr_gnt) mem_wdata <= cfg_wr_data;
    end
  // tagged read pipeline: grant, RAM strobe, RAM data, registered response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_v      <= 1'b0;
      s2_v      <= 1'b0;
      s1_tag    <= '0;
      s2_tag    <= '0;
      s1_err    <= 1'b0;
      s2_err    <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= RSP_OK;
    end else begin
      s1_v      <= rd_gnt;
      s1_tag    <= rd_idx;
      s1_err    <= !rd_in;
      s2_v      <= s1_v;
      s2_tag    <= s1_tag;
      s2_err    <= s1_err;
      rsp_valid <= s2_v ? NUM_REQ'(1) << s2_tag : '0;
      rsp_data  <= (s2_v && !s2_err) ? mem_rdata : '0;
      rsp_err   <= (s2_v && s2_err) ? RSP_ERR_RANGE : RSP_OK;
    end
endmodule

// File: tb/tb_weight_access_arbiter.sv
// tb_weight_access_arbiter: directed and random checks against a grant-order memory model
module tb_weight_access_arbiter;
  localparam int NR = 4, NS = 72832, AW = 17, DW = 16, WB = 4;
  localparam int RUN_S = 0, DRAIN_S = 1, LOCKED_S = 2;
  typedef struct {int due; int req; logic [DW-1:0] data; logic err;} rsp_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [NR-1:0] rd_valid, rd_ready, rsp_valid;
  logic [NR*AW-1:0] rd_addr;
  logic [DW-1:0] rsp_data, cfg_wr_data, mem_wdata, mem_rdata;
  logic rsp_err, cfg_wr_valid, cfg_wr_ready, cfg_wr_err, cfg_lock, lock_ack, mem_en, mem_we;
  logic [AW-1:0] cfg_wr_addr, mem_addr;
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit ram_w [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  int n_cmp, n_bad, cyc, m_ptr, m_streak, m_state, obs_g;
  bit req_v [NR];
  logic [AW-1:0] req_a [NR];
  bit wv;
  logic [AW-1:0] wa;
  logic [DW-1:0] wd;
  bit e_en, e_we, e_werr;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  rsp_t q[$];

  always #5 clk = ~clk;

  weight_access_arbiter dut (
    .clk(clk), .rst_n(rst_n), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .cfg_wr_valid(cfg_wr_valid), .cfg_wr_ready(cfg_wr_ready), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .cfg_wr_err(cfg_wr_err), .cfg_lock(cfg_lock), .lock_ack(lock_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [DW-1:0] init_val(int a);
    return DW'(a * 37 + 'h1234);
  endfunction

  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr] <= mem_wdata;
        ram_w[mem_addr] <= 1'b1;
      end else mem_rdata <= ram_w[mem_addr] ? ram[mem_addr] : init_val(int'(mem_addr));
    end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    int r = $urandom_range(0, 9);
    return r == 0 ? AW'($urandom_range(NS, (1 << AW) - 1)) : r == 1 ? AW'(NS - 1) : AW'($urandom_range(0, 15));
  endfunction

  function automatic int predict();
    bit any = 1'b0, open;
    int j;
    for (int i = 0; i < NR; i++) any |= req_v[i];
    open = m_state == RUN_S && !cfg_lock;
    if (wv && !(any && open && m_streak >= WB)) return NR;
    if (open)
      for (int k = 0; k < NR; k++) begin
        j = (m_ptr + k) % NR;
        if (req_v[j]) return j;
      end
    return -1;
  endfunction

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      rd_valid[i] = req_v[i];
      rd_addr[i*AW +: AW] = req_a[i];
    end
    cfg_wr_valid = wv;
    cfg_wr_addr = wa;
    cfg_wr_data = wd;
  endtask

  task automatic reset_model();
    q.delete();
    m_ptr = 0;
    m_streak = 0;
    m_state = RUN_S;
    e_en = 0; e_we = 0; e_werr = 0;
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_rd_ready"}, 32'(rd_ready), 0);
    chk({tag, "_wr_ready"}, 32'(cfg_wr_ready), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_wr_err"}, 32'(cfg_wr_err), 0);
    chk({tag, "_lock_ack"}, 32'(lock_ack), 0);
    chk({tag, "_mem_en"}, 32'(mem_en), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  task automatic tick();
    int g, a;
    bit inr, any, empty;
    rsp_t r;
    logic [NR-1:0] er;
    drive();
    @(negedge clk);
    any = |rd_valid;
    g = predict();
    obs_g = -1;
    for (int i = 0; i < NR; i++) if (rd_ready[i] && rd_valid[i]) obs_g = i;
    if (cfg_wr_ready && cfg_wr_valid) obs_g = NR;
    er = (g >= 0 && g < NR) ? NR'(1) << g : '0;
    chk("rd_grant", 32'(rd_ready & rd_valid), 32'(er));
    chk("wr_grant", 32'(cfg_wr_ready & cfg_wr_valid), 32'(g == NR));
    if (q.size() != 0 && q[0].due == cyc) begin
      r = q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'(NR'(1) << r.req));
      chk("rsp_data", 32'(rsp_data), 32'(r.data));
      chk("rsp_err", 32'(rsp_err), 32'(r.err));
    end else chk("rsp_valid", 32'(rsp_valid), 0);
    chk("mem_en", 32'(mem_en), 32'(e_en));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    if (e_en) chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    if (e_we) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    chk("cfg_wr_err", 32'(cfg_wr_err), 32'(e_werr));
    chk("lock_ack", 32'(lock_ack), 32'(m_state == LOCKED_S));
    empty = q.size() == 0;
    e_en = 0; e_we = 0; e_werr = 0;
    if (g == NR) begin
      inr = int'(wa) < NS;
      if (inr) exp_mem[wa] = wd;
      e_en = inr; e_we = inr; e_addr = wa; e_wdata = wd; e_werr = !inr;
      wv = 0;
    end else if (g >= 0) begin
      a = int'(req_a[g]);
      inr = a < NS;
      r.due = cyc + 3; r.req = g; r.data = inr ? exp_mem[a] : '0; r.err = !inr;
      q.push_back(r);
      e_en = inr; e_addr = req_a[g];
      m_ptr = (g + 1) % NR;
      req_v[g] = 0;
    end
    m_streak = (!any || (g >= 0 && g < NR)) ? 0 : (g == NR) ? (m_streak < WB ? m_streak + 1 : WB) : m_streak;
    if (m_state == RUN_S) m_state = cfg_lock ? DRAIN_S : RUN_S;
    else if (!cfg_lock) m_state = RUN_S;
    else if (m_state == DRAIN_S && empty) m_state = LOCKED_S;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int rd_seen;
    n_cmp = 0; n_bad = 0; cyc = 0;
    for (int i = 0; i < (1 << AW); i++) exp_mem[i] = init_val(i);
    for (int i = 0; i < NR; i++) begin req_v[i] = 0; req_a[i] = '0; end
    wv = 0; wa = '0; wd = '0; cfg_lock = 0;
    reset_model();
    rd_valid = '1; rd_addr = '0; cfg_wr_valid = 1'b1; cfg_wr_addr = '0; cfg_wr_data = '0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("rst");
    rst_n = 1'b1;
    // round robin over four held requests
    for (int i = 0; i < NR; i++) req_a[i] = AW'(i);
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NR; i++) req_v[i] = 1;
      tick();
      chk("rr_order", 32'(obs_g), 32'(k % NR));
    end
    for (int i = 0; i < NR; i++) req_v[i] = 0;
    repeat (5) tick();
    // bounded write priority with requester 2 waiting
    req_a[2] = AW'(5); req_v[2] = 1;
    for (int k = 0; k < 7; k++) begin
      wv = 1; wa = AW'(200 + k); wd = DW'(16'hA000 + k);
      tick();
      chk("wr_burst", 32'(obs_g), 32'(k == 4 ? 2 : NR));
    end
    repeat (4) tick();
    // read after write to the same address
    wv = 1; wa = AW'(100); wd = 16'hBEEF;
    tick();
    chk("beef_wr_gnt", 32'(obs_g), NR);
    req_a[0] = AW'(100); req_v[0] = 1;
    tick();
    chk("beef_rd_gnt", 32'(obs_g), 0);
    repeat (2) tick();
    chk("beef_rsp_valid", 32'(rsp_valid), 1);
    chk("beef_rsp_data", 32'(rsp_data), 32'h0000_BEEF);
    repeat (2) tick();
    // out-of-range read and write
    req_a[1] = AW'(NS); req_v[1] = 1;
    tick();
    chk("oor_rd_mem_en", 32'(mem_en), 0);
    repeat (2) tick();
    chk("oor_rsp_valid", 32'(rsp_valid), 2);
    chk("oor_rsp_err", 32'(rsp_err), 1);
    chk("oor_rsp_data", 32'(rsp_data), 0);
    wv = 1; wa = AW'(80000); wd = 16'h1111;
    tick();
    chk("oor_wr_err", 32'(cfg_wr_err), 1);
    chk("oor_wr_mem_en", 32'(mem_en), 0);
    repeat (4) tick();
    // lock with three reads in flight
    for (int i = 0; i < 3; i++) begin req_a[i] = AW'(10 + i); req_v[i] = 1; end
    repeat (3) tick();
    cfg_lock = 1; req_a[3] = AW'(20); req_v[3] = 1;
    rd_seen = 0;
    for (int k = 0; k < 6; k++) begin
      wv = 1; wa = AW'(300 + k); wd = DW'(16'hC000 + k);
      tick();
      if (obs_g >= 0 && obs_g < NR) rd_seen++;
    end
    chk("lock_no_rd", 32'(rd_seen), 0);
    chk("lock_ack_set", 32'(lock_ack), 1);
    cfg_lock = 0; wv = 0;
    tick();
    tick();
    chk("unlock_rd_gnt", 32'(obs_g), 3);
    repeat (4) tick();
    // reset with two reads in flight
    req_a[0] = AW'(7); req_a[1] = AW'(8); req_v[0] = 1; req_v[1] = 1;
    repeat (2) tick();
    req_a[2] = AW'(9); req_v[2] = 1;
    wv = 1; wa = AW'(400); wd = 16'h5555;
    drive();
    rst_n = 1'b0;
    #1;
    check_zero("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    reset_model();
    wv = 0;
    for (int i = 0; i < NR; i++) req_v[i] = 1;
    tick();
    chk("rst_first_gnt", 32'(obs_g), 0);
    repeat (6) tick();
    // random traffic
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < NR; i++)
        if (!req_v[i] && $urandom_range(0, 2) == 0) begin req_v[i] = 1; req_a[i] = rand_addr(); end
      if (!wv && $urandom_range(0, 3) == 0) begin wv = 1; wa = rand_addr(); wd = DW'($urandom); end
      if ($urandom_range(0, 59) == 0) cfg_lock = !cfg_lock;
      tick();
    end
    cfg_lock = 0;
    for (int k = 0; k < 12; k++) tick();
    for (int i = 0; i < NR; i++) req_v[i] = 0;
    wv = 0;
    repeat (8) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
